operand_arbiter: RTL and testbench

OPERAND_ARBITER -- requirements
Module: operand_arbiter

---
 rtl/operand_arbiter.sv | 151 +++++++++++++++
 tb/tb_operand_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_arbiter.sv
// Round-robin arbiter that lends one shared 2-bit combinational unit to three
// requesters: latch operands, drive them for SETTLE cycles, capture, then ack.
module operand_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [5:0] a1_in,
  input  logic [5:0] a2_in,
  input  logic [5:0] a3_in,
  output logic [1:0] u_a1,
  output logic [1:0] u_a2,
  output logic [1:0] u_a3,
  input  logic [1:0] u_y,
  output logic [2:0] gnt,
  output logic [2:0] ack,
  output logic [1:0] y_out,
  output logic       busy
);

  localparam int unsigned CW = 3;
  localparam int unsigned OW = 2;

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, ACK} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      win_q, win_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [2:0]      ack_q, ack_d;
  logic [OW-1:0]   y_q, y_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [OW-1:0]   ua1_q, ua1_d, ua2_q, ua2_d, ua3_q, ua3_d;
  logic [1:0]      pick;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : 2'(i + 2'd1);
  endfunction

  function automatic logic [OW-1:0] lane(input logic [5:0] v, input logic [1:0] i);
    case (i)
      2'd1:    return v[3:2];
      2'd2:    return v[5:4];
      default: return v[1:0];
    endcase
  endfunction

  // Round-robin search starting one past the last winner
  always_comb begin
    pick = ptr_q;
    if (req[next_idx(ptr_q)])                pick = next_idx(ptr_q);
    else if (req[next_idx(next_idx(ptr_q))]) pick = next_idx(next_idx(ptr_q));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    y_d     = y_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    op3_d   = op3_q;
    ua1_d   = '0;
    ua2_d   = '0;
    ua3_d   = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = pick;
          gnt_d   = 3'(3'd1 << pick);
          op1_d   = lane(a1_in, pick);
          op2_d   = lane(a2_in, pick);
          op3_d   = lane(a3_in, pick);
          ua1_d   = op1_d;
          ua2_d   = op2_d;
          ua3_d   = op3_d;
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        ua1_d = op1_q;
        ua2_d = op2_q;
        ua3_d = op3_q;
        if (cnt_q == CW'(SETTLE - 1)) state_d = CAPTURE;
        else                          cnt_d   = CW'(cnt_q + 1'b1);
      end
      CAPTURE: begin
        y_d     = u_y;
        ack_d   = gnt_q;
        state_d = ACK;
      end
      ACK: begin
        ptr_d   = win_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd2;
      win_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      op3_q   <= '0;
      ua1_q   <= '0;
      ua2_q   <= '0;
      ua3_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      op3_q   <= op3_d;
      ua1_q   <= ua1_d;
      ua2_q   <= ua2_d;
      ua3_q   <= ua3_d;
    end
  end

  assign u_a1  = ua1_q;
  assign u_a2  = ua2_q;
  assign u_a3  = ua3_q;
  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign y_out = y_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_operand_arbiter.sv
// Bench for operand_arbiter: two instances (SETTLE=1 and 4) against a
// transaction-timeline model, plus directed ordering and reset scenarios.
module tb_operand_arbiter;

  localparam int unsigned S0 = 1;
  localparam int unsigned S1 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [5:0] a1_in, a2_in, a3_in;
  logic [1:0] ua1 [2];
  logic [1:0] ua2 [2];
  logic [1:0] ua3 [2];
  logic [1:0] uy  [2];
  logic [2:0] gnt [2];
  logic [2:0] ack [2];
  logic [1:0] yo  [2];
  logic       bsy [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Shared unit: any fixed function of the three operands
  function automatic logic [1:0] unit_f(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return 2'(a + b) ^ c;
  endfunction

  assign uy[0] = unit_f(ua1[0], ua2[0], ua3[0]);
  assign uy[1] = unit_f(ua1[1], ua2[1], ua3[1]);

  operand_arbiter #(.SETTLE(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in),
    .u_a1(ua1[0]), .u_a2(ua2[0]), .u_a3(ua3[0]), .u_y(uy[0]),
    .gnt(gnt[0]), .ack(ack[0]), .y_out(yo[0]), .busy(bsy[0]));

  operand_arbiter #(.SETTLE(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .a1_in(a1_in), .a2_in(a2_in), .a3_in(a3_in),
    .u_a1(ua1[1]), .u_a2(ua2[1]), .u_a3(ua3[1]), .u_y(uy[1]),
    .gnt(gnt[1]), .ack(ack[1]), .y_out(yo[1]), .busy(bsy[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? int'(S0) : int'(S1);
  endfunction

  function automatic int rr_pick(input int ptr, input logic [2:0] r);
    for (int j = 1; j <= 3; j++) begin
      int idx;
      idx = (ptr + j) % 3;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  // Model: k counts edges since the selection edge; ACK phase is k == SETTLE+2
  bit         m_act [2];
  int         m_k   [2];
  int         m_win [2];
  int         m_ptr [2];
  logic [5:0] m_ops [2];
  logic [1:0] m_y   [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0;
        m_k[i]   <= 0;
        m_win[i] <= 0;
        m_ptr[i] <= 2;
        m_ops[i] <= '0;
        m_y[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          m_k[i] <= m_k[i] + 1;
          if (m_k[i] + 1 == settle_of(i) + 2) begin
            m_y[i]   <= unit_f(m_ops[i][5:4], m_ops[i][3:2], m_ops[i][1:0]);
            m_ptr[i] <= m_win[i];
          end
          if (m_k[i] + 1 == settle_of(i) + 3) m_act[i] <= 1'b0;
        end else if (req != 3'b000) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= 1;
          m_win[i] <= rr_pick(m_ptr[i], req);
          m_ops[i] <= {a1_in[2*rr_pick(m_ptr[i], req) +: 2],
                       a2_in[2*rr_pick(m_ptr[i], req) +: 2],
                       a3_in[2*rr_pick(m_ptr[i], req) +: 2]};
        end
      end
    end
  end

  // Compare every instance against the model each cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [2:0] e_gnt, e_ack;
      logic [5:0] e_ua;
      e_gnt = m_act[i] ? 3'(3'd1 << m_win[i]) : 3'd0;
      e_ack = (m_act[i] && m_k[i] == settle_of(i) + 2) ? e_gnt : 3'd0;
      e_ua  = (m_act[i] && m_k[i] <= settle_of(i) + 1) ? m_ops[i] : 6'd0;
      check($sformatf("gnt%0d", i),  32'(gnt[i]), 32'(e_gnt));
      check($sformatf("ack%0d", i),  32'(ack[i]), 32'(e_ack));
      check($sformatf("ua%0d", i),   32'({ua1[i], ua2[i], ua3[i]}), 32'(e_ua));
      check($sformatf("y%0d", i),    32'(yo[i]),  32'(m_y[i]));
      check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_act[i]));
      check($sformatf("onehot%0d", i), 32'($onehot0(gnt[i]) && $onehot0(ack[i])), 32'd1);
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [2:0] order [4];
    int         n_ack;
    bit         seen;
    rst_n = 1'b0; req = '0; a1_in = '0; a2_in = '0; a3_in = '0;
    idle_cycles(2);
    check("rst_gnt", 32'(gnt[0]), 32'd0);
    check("rst_y",   32'(yo[0]),  32'd0);
    #2 rst_n = 1'b1;

    // Single request from requester 0, operands (1,3,0), dropped mid-flight
    @(negedge clk); req = 3'b001; a1_in = 6'b000001; a2_in = 6'b000011; a3_in = 6'b000000;
    @(negedge clk); req = 3'b000;
    idle_cycles(10);

    // Requester 1 with (2,2,2), operands cleared during DRIVE
    @(negedge clk); req = 3'b010; a1_in = 6'b001000; a2_in = 6'b001000; a3_in = 6'b001000;
    @(negedge clk); req = 3'b000; a1_in = '0; a2_in = '0; a3_in = '0;
    idle_cycles(3);
    check("hold_y0", 32'(yo[0]), 32'(unit_f(2'd2, 2'd2, 2'd2)));
    idle_cycles(6);

    // All three requesting: ack order 001,010,100,001 on the SETTLE=1 instance
    do_reset();
    req = 3'b111;
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ack[0] != 3'b000) begin
        order[n_ack] = ack[0];
        n_ack++;
      end
    end
    for (int k = n_ack; k < 4; k++) order[k] = 3'b000;
    check("rr_ack0", 32'(order[0]), 32'd1);
    check("rr_ack1", 32'(order[1]), 32'd2);
    check("rr_ack2", 32'(order[2]), 32'd4);
    check("rr_ack3", 32'(order[3]), 32'd1);
    req = 3'b000;
    idle_cycles(12);

    // Reset during CAPTURE of the SETTLE=1 instance aborts with no ack
    do_reset();
    @(negedge clk); req = 3'b010; a1_in = 6'b111111;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_gnt",  32'(gnt[0]), 32'd0);
    check("abort_ack",  32'(ack[0]), 32'd0);
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_ua",   32'({ua1[0], ua2[0], ua3[0]}), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1; req = 3'b111;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt[0]), 32'd1);
    req = 3'b000;
    idle_cycles(12);

    // Requester 2 raised during ACK of requester 0 is granted right after IDLE
    @(negedge clk); req = 3'b001;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (ack[0] == 3'b001) seen = 1'b1;
    end
    check("ack_seen", 32'(seen), 32'd1);
    req = 3'b100;
    idle_cycles(2);
    check("back2back_gnt", 32'(gnt[0]), 32'd4);
    req = 3'b000;
    idle_cycles(12);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req   = 3'($urandom_range(0, 7));
      a1_in = 6'($urandom);
      a2_in = 6'($urandom);
      a3_in = 6'($urandom);
      if ($urandom_range(0, 3) == 0) req = 3'b000;
      if (c % 700 == 350) begin
        #1 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
      end
    end
    req = '0;
    idle_cycles(12);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
